// File: rtl/pending_enc_pkg.sv
// ============================================================================
// Module   : pending_enc_pkg
// Purpose  : Shared constants and helpers for the pending 8-to-3 encoder.
//            N      - number of request lines (only 8 is supported)
//            IDX_W  - index width, $clog2(N)
//            onehot8   - index -> 8-bit one-hot mask
//            prio_sel8 - (mask, start, direction) -> {found, index}
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pending_enc_pkg;

  localparam int N     = 8;
  localparam int IDX_W = $clog2(N);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } sel_t;

  function automatic logic [N-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Searches the mask starting at 'start' (inclusive), stepping upward when
  // 'up' is set and downward otherwise, wrapping modulo N. The scan runs from
  // the farthest position to the nearest so the nearest hit is the one kept.
  function automatic sel_t prio_sel8(input logic [N-1:0]     mask,
                                     input logic [IDX_W-1:0] start,
                                     input logic             up);
    sel_t             r;
    logic [IDX_W-1:0] idx;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = up ? (start + IDX_W'(k)) : (start - IDX_W'(k));
      if (mask[idx]) begin
        r.found = 1'b1;
        r.index = idx;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_sel8.sv
// ============================================================================
// Module   : prio_sel8
// Purpose  : Combinational 8-input selector with start pointer and found flag.
//            ROUND_ROBIN_EN defined   : search upward from start, wrapping.
//            ROUND_ROBIN_EN undefined : search downward from start.
// Ports    : mask  [N-1:0]     in  - candidate lines
//            start [IDX_W-1:0] in  - first position examined
//            index [IDX_W-1:0] out - selected position (0 when none)
//            found             out - at least one candidate present
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_sel8
  import pending_enc_pkg::*;
(
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] index,
  output logic             found
);

`ifdef ROUND_ROBIN_EN
  localparam logic SEARCH_UP = 1'b1;
`else
  localparam logic SEARCH_UP = 1'b0;
`endif

  sel_t sel;

  assign sel   = pending_enc_pkg::prio_sel8(mask, start, SEARCH_UP);
  assign index = sel.index;
  assign found = sel.found;

endmodule

`default_nettype wire

// File: rtl/pending_encoder8to3.sv
// ============================================================================
// Module   : pending_encoder8to3
// Purpose  : Sequential 8-to-3 encoder. Request lines are latched into a sticky
//            pending register; one index is issued per valid/ready handshake
//            and the served bit is cleared on that handshake.
//            Optional macro ROUND_ROBIN_EN selects round-robin arbitration
//            (default: highest index wins).
// Ports    : clk          in  - rising-edge clock
//            rst          in  - synchronous active-high reset
//            en           in  - capture enable for new requests
//            req   [7:0]  in  - request lines
//            ready        in  - consumer accepts y this cycle
//            y     [2:0]  out - issued index (0 when valid=0)
//            valid        out - y holds a live request
//            any          out - requests still pending after this cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pending_encoder8to3
  import pending_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             ready,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic             any
);

  logic [N-1:0]     pending;
  logic [N-1:0]     clr;
  logic [N-1:0]     remain;
  logic [N-1:0]     set_mask;
  logic [N-1:0]     pending_next;
  logic             fire;
  logic             load;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel_index;
  logic             sel_found;

  assign fire         = valid & ready;
  assign clr          = fire ? onehot8(y) : '0;
  assign remain       = pending & ~clr;
  assign set_mask     = req & {N{en}};
  // Set wins over clear, so a bit re-requested on its fire cycle stays pending.
  assign pending_next = remain | set_mask;
  assign load         = ~valid | fire;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  assign start = ptr + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(N - 1);
    end else if (fire) begin
      ptr <= y;
    end
  end
`else
  assign start = IDX_W'(N - 1);
`endif

  // Select sees 'remain' only: this cycle's new requests become visible next
  // cycle, and the bit being consumed is already masked out.
  prio_sel8 u_sel (
    .mask  (remain),
    .start (start),
    .index (sel_index),
    .found (sel_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      y       <= '0;
      valid   <= 1'b0;
      any     <= 1'b0;
    end else begin
      pending <= pending_next;
      any     <= |pending_next;
      // Output holds while stalled; an issued index is never preempted.
      if (load) begin
        if (sel_found) begin
          valid <= 1'b1;
          y     <= sel_index;
        end else begin
          valid <= 1'b0;
          y     <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pending_encoder8to3.sv
// ============================================================================
// Module   : tb_pending_encoder8to3
// Purpose  : Self-checking bench for pending_encoder8to3: directed scenarios
//            followed by randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pending_encoder8to3;

  logic       clk = 1'b0;
  logic       rst, en, ready;
  logic [7:0] req;
  logic [2:0] y;
  logic       valid, any;

  always #5 clk = ~clk;

  pending_encoder8to3 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .ready (ready),
    .y     (y),
    .valid (valid),
    .any   (any)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: set of pending request numbers plus the issued slot.
  bit [7:0] m_pend;
  int       m_y;
  bit       m_valid;
  bit       m_any;
  int       m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Arbitration choice among the requests that are eligible.
  function automatic int pick(input bit [7:0] mask, input int ptr);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++)
      if (mask[(ptr + k) % 8]) return (ptr + k) % 8;
`else
    for (int i = 7; i >= 0; i--)
      if (mask[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit [7:0] rq, input bit rd);
    bit       fire;
    bit [7:0] eligible;
    bit [7:0] nxt;
    int       old_y;
    if (r) begin
      m_pend = 0; m_y = 0; m_valid = 0; m_any = 0; m_ptr = 7;
      return;
    end
    fire     = m_valid && rd;
    old_y    = m_y;
    eligible = m_pend;
    if (fire) eligible[old_y] = 1'b0;
    nxt = eligible | (e ? rq : 8'h00);
    if (!m_valid || fire) begin
      if (eligible != 0) begin
        m_valid = 1;
        m_y     = pick(eligible, m_ptr);
      end else begin
        m_valid = 0;
        m_y     = 0;
      end
    end
    if (fire) m_ptr = old_y;
    m_pend = nxt;
    m_any  = (nxt != 0);
  endtask

  task automatic cyc(input bit r, input bit e, input bit [7:0] rq, input bit rd, input string tag);
    rst = r; en = e; req = rq; ready = rd;
    @(posedge clk);
    model_edge(r, e, rq, rd);
    #1;
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".y"},     32'(y),     32'(m_y));
    check({tag, ".any"},   32'(any),   32'(m_any));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00; ready = 1'b0;

    // Reset state
    cyc(1, 0, 8'h00, 0, "reset");
    cyc(1, 0, 8'h00, 0, "reset");
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_any",   32'(any),   32'd0);

    // Single request: visible two edges after capture, then empty
    cyc(0, 1, 8'h04, 1, "single");
    cyc(0, 0, 8'h00, 1, "single");
    check("single_y",     32'(y),     32'd2);
    check("single_valid", 32'(valid), 32'd1);
    cyc(0, 0, 8'h00, 1, "single");
    check("single_empty", 32'(valid), 32'd0);

    // Stall hold
    cyc(0, 1, 8'h81, 0, "stall");
    cyc(0, 0, 8'h00, 0, "stall");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 8'h00, 0, "stall");
      check("stall_y", 32'(y), 32'd7);
    end
    cyc(0, 0, 8'h00, 1, "stall");
    check("stall_next_y", 32'(y), 32'd0);
    cyc(0, 0, 8'h00, 1, "stall");
    check("stall_empty", 32'(valid), 32'd0);

    // Enable gating, then full drain
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 8'hFF, 1, "engate");
      check("engate_any", 32'(any), 32'd0);
    end
    cyc(0, 1, 8'hFF, 1, "drain");
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 0, 8'h00, 1, "drain");
`ifndef ROUND_ROBIN_EN
      check("drain_y", 32'(y), 32'(i));
`endif
    end
    cyc(0, 0, 8'h00, 1, "drain");
    check("drain_empty", 32'(valid), 32'd0);

    // Set-vs-clear collision: bit 3 re-requested on its fire cycle
    cyc(0, 1, 8'h08, 1, "collide");
    cyc(0, 0, 8'h00, 1, "collide");
    check("collide_y1", 32'(y), 32'd3);
    cyc(0, 1, 8'h08, 1, "collide");
    check("collide_gap", 32'(valid), 32'd0);
    cyc(0, 0, 8'h00, 1, "collide");
    check("collide_y2",     32'(y),     32'd3);
    check("collide_valid2", 32'(valid), 32'd1);
    cyc(0, 0, 8'h00, 1, "collide");

    // Reset mid-operation
    cyc(0, 1, 8'hFF, 0, "midrst");
    cyc(0, 0, 8'h00, 0, "midrst");
    cyc(1, 1, 8'hFF, 1, "midrst");
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_y",     32'(y),     32'd0);
    check("midrst_any",   32'(any),   32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, "postrst");

    // Continuous full request
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'hFF, 1, "sat");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit       r, e, rd;
      bit [7:0] rq;
      r  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 3) != 0);
      rq = 8'($urandom & $urandom & $urandom);
      rd = ($urandom_range(0, 3) != 0);
      cyc(r, e, rq, rd, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
